// File: rtl/morse_decoder.sv
// Morse key receiver: times presses/releases, assembles dots and dashes into letters A-H, drives HEX0.
// Latency: valid/err pulse GAP_END+3 clocks after the key is released at the end of a letter.
// Backpressure: none; results are one-cycle strobes and the last glyph is held on HEX0.
module morse_decoder #(
  parameter int CW        = 26,
  parameter int MIN_PRESS = 500000,
  parameter int DASH_MIN  = 37500000,
  parameter int GAP_END   = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_n,
  output logic [2:0] letter,
  output logic       valid,
  output logic       err,
  output logic       busy,
  output logic [0:6] HEX0
);

  localparam logic [CW-1:0] MIN_C  = CW'(MIN_PRESS);
  localparam logic [CW-1:0] DASH_C = CW'(DASH_MIN);
  localparam logic [CW-1:0] GAP_C  = CW'(GAP_END);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    len;
  logic [3:0]    pat;
  logic          sync_1;
  logic          sync_2;
  logic          k;
  logic          dec_ok;
  logic [2:0]    dec_idx;

  // glyph for a decoded letter index, segments a..g active-low
  function automatic logic [0:6] glyph(input logic [2:0] idx);
    case (idx)
      3'd0:    glyph = 7'b0001000; // A
      3'd1:    glyph = 7'b1100000; // b
      3'd2:    glyph = 7'b0110001; // C
      3'd3:    glyph = 7'b1000010; // d
      3'd4:    glyph = 7'b0110000; // E
      3'd5:    glyph = 7'b0111000; // F
      3'd6:    glyph = 7'b0100001; // G
      default: glyph = 7'b1001000; // H
    endcase
  endfunction

  // two-stage synchronizer for the asynchronous key; idles released (1)
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
    end
  end

  assign k    = ~sync_2;
  assign busy = (state != IDLE);

  // code table lookup; bits of pat above len are always zero, so only the low len bits matter
  always_comb begin
    dec_ok  = 1'b0;
    dec_idx = 3'd0;
    case (len)
      3'd1: if (pat[0] == 1'b0) begin dec_ok = 1'b1; dec_idx = 3'd4; end
      3'd2: if (pat[1:0] == 2'b01) begin dec_ok = 1'b1; dec_idx = 3'd0; end
      3'd3: begin
        if (pat[2:0] == 3'b100) begin dec_ok = 1'b1; dec_idx = 3'd3; end
        if (pat[2:0] == 3'b110) begin dec_ok = 1'b1; dec_idx = 3'd6; end
      end
      3'd4: begin
        case (pat)
          4'b1000: begin dec_ok = 1'b1; dec_idx = 3'd1; end
          4'b1010: begin dec_ok = 1'b1; dec_idx = 3'd2; end
          4'b0010: begin dec_ok = 1'b1; dec_idx = 3'd5; end
          4'b0000: begin dec_ok = 1'b1; dec_idx = 3'd7; end
          default: ;
        endcase
      end
      default: ; // len 0 cannot reach decode; len 5 is overflow
    endcase
  end

  // press/gap timing FSM; the result is registered on entry to DONE so it is visible during DONE
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      len    <= 3'd0;
      pat    <= 4'd0;
      letter <= 3'd0;
      valid  <= 1'b0;
      err    <= 1'b0;
      HEX0   <= 7'b1111111;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (k) begin
            state <= PRESS;
            cnt   <= ONE_C;
          end
        end
        PRESS: begin
          if (!k) begin
            if (cnt < MIN_C) begin
              // bounce: drop it; if symbols are pending, restart gap timing from the release
              state <= (len != 3'd0) ? GAP : IDLE;
              cnt   <= (len != 3'd0) ? ONE_C : '0;
            end else begin
              pat   <= {pat[2:0], (cnt >= DASH_C)};
              if (len != 3'd5) len <= len + 3'd1;
              state <= GAP;
              cnt   <= ONE_C;
            end
          end else if (cnt != '1) begin
            cnt <= cnt + ONE_C;
          end
        end
        GAP: begin
          // a press takes priority over the gap expiring in the same cycle
          if (k) begin
            state <= PRESS;
            cnt   <= ONE_C;
          end else if (cnt == GAP_C) begin
            state <= DONE;
            if (dec_ok) begin
              valid  <= 1'b1;
              letter <= dec_idx;
              HEX0   <= glyph(dec_idx);
            end else begin
              err  <= 1'b1;
              HEX0 <= 7'b1111110;
            end
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        DONE: begin
          len   <= 3'd0;
          pat   <= 4'd0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with short timing (unit = 4 clocks).
// Each task drives one scenario and checks results inline.
// Pulse counts come from a negedge monitor of valid/err.
module tb_morse_decoder;

  logic       CLOCK_50;
  logic       reset;
  logic       key_n;
  logic [2:0] letter;
  logic       valid;
  logic       err;
  logic       busy;
  logic [0:6] HEX0;

  int total;
  int bad;
  int valid_cnt;
  int err_cnt;
  int both_cnt;
  int cyc;
  int valid_cyc;
  int rise_cyc;

  morse_decoder #(
    .CW(8), .MIN_PRESS(2), .DASH_MIN(6), .GAP_END(8)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .key_n(key_n),
    .letter(letter),
    .valid(valid),
    .err(err),
    .busy(busy),
    .HEX0(HEX0)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (valid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (err) err_cnt = err_cnt + 1;
    if (valid && err) both_cnt = both_cnt + 1;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic key_press(input int n);
    key_n = 1'b0;
    repeat (n) tick();
    key_n = 1'b1;
  endtask

  task automatic key_release(input int n);
    key_n = 1'b1;
    repeat (n) tick();
  endtask

  task automatic clear_mon();
    valid_cnt = 0;
    err_cnt   = 0;
    valid_cyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    key_n = 1'b1;
    repeat (3) tick();
    total++; if (letter !== 3'd0) begin bad++; $display("FAIL reset_letter got=%0d want=0", letter); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (HEX0 !== 7'b1111111) begin bad++; $display("FAIL reset_hex got=%b want=1111111", HEX0); end
    reset = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_letter_a();
    clear_mon();
    key_press(4);
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL a_busy_mid got=%b want=1", busy); end
    key_release(3);
    key_press(8);
    key_release(12);
    total++; if (valid_cnt !== 1) begin bad++; $display("FAIL a_valid_cnt got=%0d want=1", valid_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL a_err_cnt got=%0d want=0", err_cnt); end
    total++; if (letter !== 3'd0) begin bad++; $display("FAIL a_letter got=%0d want=0", letter); end
    total++; if (HEX0 !== 7'b0001000) begin bad++; $display("FAIL a_hex got=%b want=0001000", HEX0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL a_busy_end got=%b want=0", busy); end
    key_release(4);
  endtask

  task automatic test_letter_c();
    clear_mon();
    key_press(8); key_release(4);
    key_press(4); key_release(4);
    key_press(8); key_release(4);
    key_press(4);
    rise_cyc = cyc;
    key_release(14);
    total++; if (valid_cnt !== 1) begin bad++; $display("FAIL c_valid_cnt got=%0d want=1", valid_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL c_err_cnt got=%0d want=0", err_cnt); end
    total++; if (letter !== 3'd2) begin bad++; $display("FAIL c_letter got=%0d want=2", letter); end
    total++; if (HEX0 !== 7'b0110001) begin bad++; $display("FAIL c_hex got=%b want=0110001", HEX0); end
    total++; if (valid_cyc - rise_cyc !== 11) begin bad++; $display("FAIL c_latency got=%0d want=11", valid_cyc - rise_cyc); end
  endtask

  task automatic test_overflow();
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      key_press(4);
      key_release(4);
    end
    key_press(4);
    key_release(14);
    total++; if (err_cnt !== 1) begin bad++; $display("FAIL ovf_err_cnt got=%0d want=1", err_cnt); end
    total++; if (valid_cnt !== 0) begin bad++; $display("FAIL ovf_valid_cnt got=%0d want=0", valid_cnt); end
    total++; if (HEX0 !== 7'b1111110) begin bad++; $display("FAIL ovf_hex got=%b want=1111110", HEX0); end
    total++; if (letter !== 3'd2) begin bad++; $display("FAIL ovf_letter got=%0d want=2", letter); end
  endtask

  task automatic test_glitch();
    clear_mon();
    key_press(1);
    key_release(3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b want=0", busy); end
    key_release(17);
    total++; if (valid_cnt !== 0) begin bad++; $display("FAIL glitch_valid_cnt got=%0d want=0", valid_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL glitch_err_cnt got=%0d want=0", err_cnt); end
  endtask

  task automatic test_gap_edge();
    clear_mon();
    key_press(4);
    key_release(8);
    key_press(8);
    key_release(14);
    total++; if (valid_cnt !== 1) begin bad++; $display("FAIL edge_valid_cnt got=%0d want=1", valid_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL edge_err_cnt got=%0d want=0", err_cnt); end
    total++; if (letter !== 3'd0) begin bad++; $display("FAIL edge_letter got=%0d want=0", letter); end
    total++; if (HEX0 !== 7'b0001000) begin bad++; $display("FAIL edge_hex got=%b want=0001000", HEX0); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    key_press(8); key_release(4);
    key_n = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    total++; if (HEX0 !== 7'b1111111) begin bad++; $display("FAIL mid_hex got=%b want=1111111", HEX0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if (letter !== 3'd0) begin bad++; $display("FAIL mid_letter got=%0d want=0", letter); end
    key_n = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after got=%b want=0", busy); end
    clear_mon();
    key_press(4);
    key_release(14);
    total++; if (valid_cnt !== 1) begin bad++; $display("FAIL e_valid_cnt got=%0d want=1", valid_cnt); end
    total++; if (letter !== 3'd4) begin bad++; $display("FAIL e_letter got=%0d want=4", letter); end
    total++; if (HEX0 !== 7'b0110000) begin bad++; $display("FAIL e_hex got=%b want=0110000", HEX0); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; both_cnt = 0;
    valid_cnt = 0; err_cnt = 0; valid_cyc = -1; rise_cyc = 0;
    reset = 1'b0;
    key_n = 1'b1;
    test_reset();
    test_letter_a();
    test_letter_c();
    test_overflow();
    test_glitch();
    test_gap_edge();
    test_reset_mid();
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL valid_err_overlap got=%0d want=0", both_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
